vga_pixel_fetch: RTL and testbench

// Pixel source stage between the VGA timing controller and the RGB output pins.
// - Takes the controller's h_count/v_count/bright/hs/vs and reads a low-res framebuffer (FB_W x FB_H, upscaled by 2**SCALE_LOG2).
// - Issues one read per visible pixel to a fixed-latency memory.
// - Delays sync and blank so rgb, hs and vs leave the block cycle-aligned.

---
 rtl/vga_pkg.sv | 12 +
 rtl/vga_delay_line.sv | 27 ++
 rtl/vga_pixel_fetch.sv | 105 ++++++++++
 tb/tb_vga_pixel_fetch.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: 800x525 frame timing, visible area and colour encoding
// for the one-bit-per-channel RGB path.
package vga_pkg;
  localparam int H_LAST    = 799;
  localparam int V_LAST    = 524;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int PIX_W     = 3;

  localparam logic [PIX_W-1:0] BLACK = 3'b000;
  localparam logic [PIX_W-1:0] WHITE = 3'b111;
endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous active-low reset to a chosen value,
// used to keep blank/sync/bar bits aligned with the framebuffer read path.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Pixel source between the VGA timing controller and the RGB pins: reads an
// upscaled low-res framebuffer and delays blank/sync so everything leaves aligned.
module vga_pixel_fetch #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int ADDR_W     = 15,
  parameter int PIX_W      = vga_pkg::PIX_W,
  parameter int MEM_LAT    = 1,
  parameter int H_LAST     = vga_pkg::H_LAST,
  parameter int V_LAST     = vga_pkg::V_LAST
) (
  input  logic              clk_25,
  input  logic              reset_n,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              bright,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              test_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  rgb,
  output logic              hs,
  output logic              vs
);
  import vga_pkg::*;

  // The output register adds the final cycle, so the lines are one short of L.
  localparam int                DLY_DEPTH = MEM_LAT + 1;
  localparam int                SUB_W     = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam logic [SUB_W-1:0]  SUB_MAX   = SUB_W'((2 ** SCALE_LOG2) - 1);
  localparam logic [9:0]        V_ACTIVE  = 10'(FB_H << SCALE_LOG2);
  localparam logic [9:0]        H_END     = 10'(H_LAST);
  localparam logic [9:0]        V_END     = 10'(V_LAST);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(FB_W);

  logic [ADDR_W-1:0] row_base;
  logic [SUB_W-1:0]  sub_line;
  logic              bright_d;
  logic              hs_d;
  logic              vs_d;
  logic [2:0]        bar_d;

  // Row base advances by FB_W every 2**SCALE_LOG2 visible lines; no multiplier.
  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      row_base <= '0;
      sub_line <= '0;
    end else if (h_count == H_END) begin
      if (v_count == V_END) begin
        row_base <= '0;
        sub_line <= '0;
      end else if (v_count < V_ACTIVE) begin
        if (sub_line == SUB_MAX) begin
          row_base <= row_base + ROW_STEP;
          sub_line <= '0;
        end else begin
          sub_line <= sub_line + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_rd   <= bright;
      mem_addr <= row_base + ADDR_W'(h_count >> SCALE_LOG2);
    end
  end

  vga_delay_line #(.WIDTH(1), .DEPTH(DLY_DEPTH), .RST_VAL(1'b0)) u_dly_bright (
    .clk(clk_25), .reset_n(reset_n), .din(bright), .dout(bright_d)
  );

  vga_delay_line #(.WIDTH(1), .DEPTH(DLY_DEPTH), .RST_VAL(1'b1)) u_dly_hs (
    .clk(clk_25), .reset_n(reset_n), .din(hs_in), .dout(hs_d)
  );

  vga_delay_line #(.WIDTH(1), .DEPTH(DLY_DEPTH), .RST_VAL(1'b1)) u_dly_vs (
    .clk(clk_25), .reset_n(reset_n), .din(vs_in), .dout(vs_d)
  );

  vga_delay_line #(.WIDTH(3), .DEPTH(DLY_DEPTH), .RST_VAL(3'b000)) u_dly_bar (
    .clk(clk_25), .reset_n(reset_n), .din(h_count[9:7]), .dout(bar_d)
  );

  // test_en is deliberately undelayed so the bar/framebuffer switch acts at once.
  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      rgb <= BLACK;
      hs  <= 1'b1;
      vs  <= 1'b1;
    end else begin
      rgb <= !bright_d ? BLACK : (test_en ? PIX_W'(bar_d) : mem_rdata);
      hs  <= hs_d;
      vs  <= vs_d;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: drives partial 800x525 timing (full lines
// where detail matters, single end-of-line cycles elsewhere) with a 1-cycle memory.
module tb_vga_pixel_fetch;

  logic        clk_25 = 1'b0;
  logic        reset_n;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        bright;
  logic        hs_in;
  logic        vs_in;
  logic        test_en;
  logic        mem_rd;
  logic [14:0] mem_addr;
  logic [2:0]  mem_rdata = 3'd0;
  logic [2:0]  rgb;
  logic        hs;
  logic        vs;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       b;
    logic       h;
    logic       v;
    logic [2:0] bar;
    logic [2:0] pix;
  } ent_t;

  localparam ent_t RST_E = '{b: 1'b0, h: 1'b1, v: 1'b1, bar: 3'd0, pix: 3'd0};

  ent_t       d0, d1, d2;
  logic [2:0] exp_rgb;
  logic       exp_hs;
  logic       exp_vs;

  always #20 clk_25 = ~clk_25;

  vga_pixel_fetch dut (
    .clk_25   (clk_25),
    .reset_n  (reset_n),
    .h_count  (h_count),
    .v_count  (v_count),
    .bright   (bright),
    .hs_in    (hs_in),
    .vs_in    (vs_in),
    .test_en  (test_en),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .rgb      (rgb),
    .hs       (hs),
    .vs       (vs)
  );

  // One-cycle memory whose contents are addr[2:0]; idle reads return white.
  always @(posedge clk_25) mem_rdata <= mem_rd ? mem_addr[2:0] : 3'b111;

  function automatic int addr_of(input int h, input int v);
    return (v / 4) * 160 + h / 4;
  endfunction

  function automatic logic [2:0] pix_of(input int h, input int v);
    int a;
    a = addr_of(h, v);
    return a[2:0];
  endfunction

  task automatic set_pos(input int h, input int v);
    h_count = 10'(h);
    v_count = 10'(v);
    bright  = (h < 640) && (v < 480);
    hs_in   = !((h >= 656) && (h <= 751));
    vs_in   = !((v >= 490) && (v <= 491));
  endtask

  // Advance one clock; expected outputs come from inputs two ticks back
  // (three edges: fetch, memory, output register).
  task automatic tick();
    ent_t e;
    e.b   = bright;
    e.h   = hs_in;
    e.v   = vs_in;
    e.bar = h_count[9:7];
    e.pix = pix_of(int'(h_count), int'(v_count));
    @(posedge clk_25);
    #1;
    if (!reset_n) begin
      d0 = RST_E; d1 = RST_E; d2 = RST_E;
    end else begin
      d2 = d1; d1 = d0; d0 = e;
    end
    exp_rgb = d2.b ? (test_en ? d2.bar : d2.pix) : 3'd0;
    exp_hs  = d2.h;
    exp_vs  = d2.v;
  endtask

  task automatic test_reset();
    set_pos(200, 10);
    hs_in   = 1'b0;
    vs_in   = 1'b0;
    test_en = 1'b1;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rgb !== 3'd0 || hs !== 1'b1 || vs !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 15'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got rgb=%0d hs=%b vs=%b rd=%b addr=%0d want 0 1 1 0 0",
                 i, rgb, hs, vs, mem_rd, mem_addr);
      end
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 15'd50) begin
      errors++;
      $display("FAIL release_fetch got rd=%b addr=%0d want 1 50", mem_rd, mem_addr);
    end
    checks++;
    if (rgb !== 3'd0 || hs !== 1'b1 || vs !== 1'b1) begin
      errors++;
      $display("FAIL release_c1 got rgb=%0d hs=%b vs=%b want 0 1 1", rgb, hs, vs);
    end
    tick();
    checks++;
    if (rgb !== 3'd0 || hs !== 1'b1 || vs !== 1'b1) begin
      errors++;
      $display("FAIL release_c2 got rgb=%0d hs=%b vs=%b want 0 1 1", rgb, hs, vs);
    end
    tick();
    checks++;
    if (rgb !== 3'd1 || hs !== 1'b0 || vs !== 1'b0) begin
      errors++;
      $display("FAIL release_c3 got rgb=%0d hs=%b vs=%b want 1 0 0", rgb, hs, vs);
    end
    test_en = 1'b0;
  endtask

  task automatic test_address();
    int vlist[6] = '{0, 1, 2, 3, 4, 479};
    test_en = 1'b0;
    set_pos(799, 524);
    tick();
    foreach (vlist[k]) begin
      if (vlist[k] == 479) begin
        for (int v = 5; v < 479; v++) begin
          set_pos(799, v);
          tick();
          checks++;
          if (rgb !== exp_rgb) begin
            errors++;
            $display("FAIL fast_rgb v=%0d got %0d want %0d", v, rgb, exp_rgb);
          end
        end
      end
      for (int h = 0; h < 800; h++) begin
        set_pos(h, vlist[k]);
        tick();
        checks++;
        if (mem_rd !== bright) begin
          errors++;
          $display("FAIL mem_rd v=%0d h=%0d got %b want %b", vlist[k], h, mem_rd, bright);
        end
        if (bright) begin
          checks++;
          if (int'(mem_addr) != addr_of(h, vlist[k])) begin
            errors++;
            $display("FAIL addr v=%0d h=%0d got %0d want %0d", vlist[k], h, mem_addr, addr_of(h, vlist[k]));
          end
        end
        checks++;
        if (rgb !== exp_rgb || hs !== exp_hs || vs !== exp_vs) begin
          errors++;
          $display("FAIL pixel v=%0d h=%0d got rgb=%0d hs=%b vs=%b want %0d %b %b",
                   vlist[k], h, rgb, hs, vs, exp_rgb, exp_hs, exp_vs);
        end
        if ((vlist[k] == 3 && h == 639 && mem_addr !== 15'd159) ||
            (vlist[k] == 4 && h == 0 && mem_addr !== 15'd160) ||
            (vlist[k] == 479 && h == 639 && mem_addr !== 15'd19199)) begin
          errors++;
          $display("FAIL addr_edge v=%0d h=%0d got %0d", vlist[k], h, mem_addr);
        end
        if ((vlist[k] == 3 && h == 639) || (vlist[k] == 4 && h == 0) || (vlist[k] == 479 && h == 639))
          checks++;
      end
    end
  endtask

  task automatic test_sync();
    int vlist[5] = '{480, 489, 490, 491, 492};
    int hs_run = 0;
    int vs_low = 0;
    for (int k = 0; k < 5; k++) begin
      if (vlist[k] == 489) begin
        for (int v = 481; v < 489; v++) begin
          set_pos(799, v);
          tick();
        end
      end
      for (int h = 0; h < 800; h++) begin
        set_pos(h, vlist[k]);
        tick();
        checks++;
        if (rgb !== 3'd0 || mem_rd !== 1'b0) begin
          errors++;
          $display("FAIL vblank v=%0d h=%0d got rgb=%0d rd=%b want 0 0", vlist[k], h, rgb, mem_rd);
        end
        checks++;
        if (hs !== exp_hs || vs !== exp_vs) begin
          errors++;
          $display("FAIL sync_align v=%0d h=%0d got hs=%b vs=%b want %b %b", vlist[k], h, hs, vs, exp_hs, exp_vs);
        end
        if (!vs) vs_low++;
        if (!hs) begin
          hs_run++;
        end else if (hs_run != 0) begin
          checks++;
          if (hs_run != 96) begin
            errors++;
            $display("FAIL hs_width v=%0d got %0d want 96", vlist[k], hs_run);
          end
          hs_run = 0;
        end
      end
    end
    checks++;
    if (vs_low != 1600) begin
      errors++;
      $display("FAIL vs_width got %0d want 1600", vs_low);
    end
    for (int v = 493; v <= 524; v++) begin
      set_pos(799, v);
      tick();
    end
  endtask

  task automatic test_pattern();
    test_en = 1'b1;
    for (int v = 0; v < 2; v++) begin
      for (int h = 0; h < 800; h++) begin
        if (v == 1 && h == 520) test_en = 1'b0;
        set_pos(h, v);
        tick();
        checks++;
        if (rgb !== exp_rgb) begin
          errors++;
          $display("FAIL pattern v=%0d h=%0d got %0d want %0d", v, h, rgb, exp_rgb);
        end
        if ((v == 0 && h == 3   && rgb !== 3'd0) || (v == 0 && h == 515 && rgb !== 3'd4) ||
            (v == 0 && h == 641 && rgb !== 3'd4) || (v == 0 && h == 642 && rgb !== 3'd0) ||
            (v == 1 && h == 519 && rgb !== 3'd4) || (v == 1 && h == 520 && rgb !== 3'd1)) begin
          errors++;
          $display("FAIL bar_edge v=%0d h=%0d got %0d", v, h, rgb);
        end
        if ((v == 0 && (h == 3 || h == 515 || h == 641 || h == 642)) || (v == 1 && (h == 519 || h == 520)))
          checks++;
      end
    end
    test_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int v = 2; v < 200; v++) begin
      set_pos(799, v);
      tick();
    end
    set_pos(100, 200);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int h = 102; h < 800; h++) begin
      set_pos(h, 200);
      tick();
    end
    set_pos(0, 201);
    tick();
    checks++;
    if (mem_addr !== 15'd0) begin
      errors++;
      $display("FAIL midrst_row201 got %0d want 0", mem_addr);
    end
    for (int v = 201; v < 204; v++) begin
      set_pos(799, v);
      tick();
    end
    set_pos(0, 204);
    tick();
    checks++;
    if (mem_addr !== 15'd160) begin
      errors++;
      $display("FAIL midrst_row204 got %0d want 160", mem_addr);
    end
    for (int v = 204; v <= 524; v++) begin
      set_pos(799, v);
      tick();
    end
    for (int v = 0; v < 5; v++) begin
      for (int h = 0; h < 800; h++) begin
        set_pos(h, v);
        tick();
        if (bright) begin
          checks++;
          if (int'(mem_addr) != addr_of(h, v)) begin
            errors++;
            $display("FAIL midrst_addr v=%0d h=%0d got %0d want %0d", v, h, mem_addr, addr_of(h, v));
          end
        end
        checks++;
        if (rgb !== exp_rgb) begin
          errors++;
          $display("FAIL midrst_rgb v=%0d h=%0d got %0d want %0d", v, h, rgb, exp_rgb);
        end
      end
    end
  endtask

  initial begin
    d0 = RST_E; d1 = RST_E; d2 = RST_E;
    reset_n = 1'b0;
    test_en = 1'b0;
    set_pos(0, 0);
    test_reset();
    test_address();
    test_sync();
    test_pattern();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
